// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan driver with dead-time, PWM, blanking, blink and frame snapshot
module seg_scan_ctrl #(
  parameter int DIGITS  = 8,
  parameter int SEG_W   = 8,
  parameter int DUTY_W  = 3,
  parameter int BLINK_W = 6,
  localparam int IW     = $clog2(DIGITS)
) (
  input  logic                    clk_slow,
  input  logic                    rst,
  input  logic [DIGITS*SEG_W-1:0] seg_in,
  input  logic [DUTY_W-1:0]       brightness,
  input  logic [DIGITS-1:0]       digit_mask,
  input  logic [DIGITS-1:0]       blink_mask,
  output logic [DIGITS-1:0]       seg_en,
  output logic [SEG_W-1:0]        seg_out,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_start
);
  logic [IW-1:0]           idx_q, idx_d;
  logic [DUTY_W-1:0]       ph_q, ph_d;
  logic [BLINK_W-1:0]      frm_q, frm_d;
  logic [DIGITS*SEG_W-1:0] shd_q;
  logic [DUTY_W-1:0]       bri_q;
  logic [DIGITS-1:0]       dm_q, bm_q;
  logic                    boff_q;
  logic [DIGITS-1:0]       en_q, en_d;
  logic [SEG_W-1:0]        out_q;
  logic [IW-1:0]           didx_q;
  logic                    fs_q;
  logic                    dead, fstart, lit;
  logic [SEG_W-1:0]        pat;

  // next counter values and next output values, all from the pre-edge (idx,ph)
  always_comb begin
    dead   = ph_q == '0;
    fstart = dead && idx_q == '0;
    ph_d   = ph_q + 1'b1;
    idx_d  = &ph_q ? (idx_q == IW'(DIGITS-1) ? '0 : idx_q + 1'b1) : idx_q;
    frm_d  = (&ph_q && idx_q == IW'(DIGITS-1)) ? frm_q + 1'b1 : frm_q;
    lit    = !dead && ph_q <= bri_q && !dm_q[idx_q] && !(bm_q[idx_q] && boff_q);
    en_d   = lit ? ~(DIGITS'(1) << idx_q) : '1;
    pat    = idx_q == '0 ? seg_in[SEG_W-1:0] : shd_q[idx_q*SEG_W +: SEG_W];
  end

  // phase, digit and frame counters
  always_ff @(posedge clk_slow or posedge rst)
    if (rst) begin
      ph_q  <= '0;
      idx_q <= '0;
      frm_q <= '0;
    end else begin
      ph_q  <= ph_d;
      idx_q <= idx_d;
      frm_q <= frm_d;
    end

  // per-slot sampling of display controls and per-frame snapshot of the patterns
  always_ff @(posedge clk_slow or posedge rst)
    if (rst) begin
      shd_q  <= '0;
      bri_q  <= '0;
      dm_q   <= '0;
      bm_q   <= '0;
      boff_q <= 1'b0;
    end else if (dead) begin
      bri_q  <= brightness;
      dm_q   <= digit_mask;
      bm_q   <= blink_mask;
      boff_q <= frm_q[BLINK_W-1];
      if (fstart) shd_q <= seg_in;
    end

  // registered pin outputs; pattern and index only change on the dark dead-time edge
  always_ff @(posedge clk_slow or posedge rst)
    if (rst) begin
      en_q   <= '1;
      out_q  <= '0;
      didx_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      en_q   <= en_d;
      fs_q   <= fstart;
      out_q  <= dead ? pat : out_q;
      didx_q <= dead ? idx_q : didx_q;
    end

  assign seg_en      = en_q;
  assign seg_out     = out_q;
  assign digit_idx   = didx_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scoreboard bench for seg_scan_ctrl (4 digits, 4-cycle slots)
module tb_seg_scan_ctrl;
  logic        clk_slow = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seg_in = '0;
  logic [1:0]  brightness = '0;
  logic [3:0]  digit_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  seg_en;
  logic [7:0]  seg_out;
  logic [1:0]  digit_idx;
  logic        frame_start;

  typedef struct {
    logic [3:0] en;
    logic [7:0] out;
    logic [1:0] idx;
    logic       fs;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          c;
  logic [31:0] sh;
  logic [1:0]  hb;
  logic [3:0]  hdm, hbm;
  logic        hboff;
  logic [7:0]  pout;
  logic [1:0]  pidx;

  seg_scan_ctrl #(.DIGITS(4), .SEG_W(8), .DUTY_W(2), .BLINK_W(2)) dut (
    .clk_slow(clk_slow), .rst(rst), .seg_in(seg_in), .brightness(brightness),
    .digit_mask(digit_mask), .blink_mask(blink_mask), .seg_en(seg_en),
    .seg_out(seg_out), .digit_idx(digit_idx), .frame_start(frame_start)
  );

  always #5 clk_slow = ~clk_slow;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    c = 0; sh = '0; pout = '0; pidx = '0; hb = '0; hdm = '0; hbm = '0; hboff = 1'b0;
    q.delete();
  endtask

  // predict the outputs of the coming edge from the edge count since reset, then compare after it
  task automatic step();
    exp_t e;
    int   ph, id, fr;
    ph = c % 4; id = (c / 4) % 4; fr = (c / 16) % 4;
    if (ph == 0) begin
      hb = brightness; hdm = digit_mask; hbm = blink_mask; hboff = fr >= 2;
      pout = id == 0 ? seg_in[7:0] : sh[id*8 +: 8];
      if (id == 0) sh = seg_in;
      pidx = 2'(id);
      e.en = 4'hF;
      e.fs = id == 0;
    end else begin
      e.en = (ph <= int'(hb) && !hdm[id] && !(hbm[id] && hboff)) ? ~(4'b0001 << id) : 4'hF;
      e.fs = 1'b0;
    end
    e.out = pout;
    e.idx = pidx;
    q.push_back(e);
    c++;
    @(posedge clk_slow); #1;
    e = q.pop_front();
    chk("seg_en", 32'(seg_en), 32'(e.en));
    chk("seg_out", 32'(seg_out), 32'(e.out));
    chk("digit_idx", 32'(digit_idx), 32'(e.idx));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("onehot_low", 32'($countones(~seg_en) <= 1), 32'd1);
  endtask

  initial begin
    int lit0, litb, nfs;
    model_reset();
    seg_in = 32'h44332211;
    brightness = 2'd3;
    repeat (2) @(posedge clk_slow);
    #1;
    chk("rst_en", 32'(seg_en), 32'hF);
    chk("rst_out", 32'(seg_out), 32'h0);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    rst = 1'b0;
    step();
    chk("rel_fs", 32'(frame_start), 32'd1);
    chk("rel_en1", 32'(seg_en), 32'hF);
    step();
    chk("rel_en2", 32'(seg_en), 32'hE);
    chk("rel_out", 32'(seg_out), 32'h11);
    repeat (14) step();
    brightness = 2'd1;
    repeat (16) step();
    brightness = 2'd0;
    repeat (16) step();
    brightness = 2'd3;
    repeat (6) step();
    seg_in = 32'hAABBCCDD;
    repeat (2) step();
    step();
    chk("stale_d2", 32'(seg_out), 32'h33);
    repeat (4) step();
    chk("stale_d3", 32'(seg_out), 32'h44);
    repeat (3) step();
    step();
    chk("new_d0", 32'(seg_out), 32'hDD);
    repeat (15) step();
    repeat (2) step();
    chk("pre_rst_lit", 32'(seg_en), 32'hE);
    rst = 1'b1;
    #1;
    chk("midrst_en", 32'(seg_en), 32'hF);
    chk("midrst_out", 32'(seg_out), 32'h0);
    chk("midrst_idx", 32'(digit_idx), 32'h0);
    digit_mask = 4'b0100;
    blink_mask = 4'b0001;
    seg_in = 32'h44332211;
    @(posedge clk_slow); #1;
    rst = 1'b0;
    model_reset();
    for (int f = 0; f < 4; f++) begin
      lit0 = 0; litb = 0; nfs = 0;
      for (int k = 0; k < 16; k++) begin
        step();
        if (seg_en == 4'hE) lit0++;
        if (seg_en == 4'hB) litb++;
        if (frame_start) begin
          nfs++;
          chk("fs_idx", 32'(digit_idx), 32'h0);
        end
      end
      chk("blink_lit0", 32'(lit0), f < 2 ? 32'd3 : 32'd0);
      chk("dmask_d2", 32'(litb), 32'd0);
      chk("fs_per_frame", 32'(nfs), 32'd1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
